mux_share_arbiter: RTL
======================

# mux_share_arbiter

Round-robin, time-sliced arbiter that shares one WIDTH-bit output path between two requesters, A and B. It generates the select line for the 2:1 selection datapath and registers the chosen word onto a single output. Typical board use: two switch banks or producer blocks driving one LED bank. A requester keeps ownership until it drops its request, or until its time slice expires while the other side is waiting.

## Interface
Parameters:
- WIDTH, 8, data width of each source and of the output
- SLICE, 4, maximum consecutive owned cycles while the other side is requesting; legal range 1..255

Ports:
- clk  input  1  system clock, rising-edge
- resetn  input  1  asynchronous, active-low reset
- req_a  input  1  requester A wants the output
- req_b  input  1  requester B wants the output
- data_a  input  WIDTH  source A word (selected when sel=0)
- data_b  input  WIDTH  source B word (selected when sel=1)
- grant_a  output  1  A owns the output this cycle (registered)
- grant_b  output  1  B owns the output this cycle (registered)
- sel  output  1  select line for the shared 2:1 path: 0=A, 1=B (registered)
- data_out  output  WIDTH  registered selected word
- data_valid  output  1  data_out holds a word captured from an owner

## Operation
- States: IDLE, OWN_A, OWN_B. grant_a=1 only in OWN_A; grant_b=1 only in OWN_B; never both.
- last_owner flag: reset value B, so A wins the first tie. Updated on every entry into OWN_A/OWN_B.
- IDLE:
  - req_a only -> OWN_A
  - req_b only -> OWN_B
  - both -> the side not equal to last_owner
  - neither -> stay in IDLE
- OWN_X: the slice counter loads 1 on entry and increments each owned cycle, saturating at SLICE.
  - req_X=0 (release): go to OWN_other if the other side requests, else IDLE.
  - req_X=1, counter==SLICE, other side requests (preempt): go to OWN_other.
  - req_X=1, other side idle: stay in OWN_X indefinitely; the counter stays at SLICE.
- Release and slice expiry in the same cycle: treat as release.
- sel: 1 in OWN_B, 0 in OWN_A. Holds its previous value in IDLE.
- Each edge: data_out <= (grant_b ? data_b : data_a) if a grant is active, else hold. data_valid <= grant_a | grant_b.
- Counter width is 8 bits. The comparison is against SLICE.

## Timing
- Reset values (asynchronous, immediate on resetn=0): state IDLE, grant_a=0, grant_b=0, sel=0, data_out=0, data_valid=0, counter=0, last_owner=B.
- Request-to-grant latency: 1 clock. A request sampled high at edge n gives a grant after edge n.
- Grant-to-data latency: 1 clock. The word present during grant cycle n appears on data_out after edge n+1, with data_valid=1.
- Handover with no gap: the old grant falls and the new grant rises at the same edge; sel flips at that edge.
- Release to IDLE: the grant falls 1 clock after req drops. data_valid falls 1 clock after that.
- Maximum wait for a requester while the other side requests continuously: SLICE cycles, plus 1 cycle of request latency.
- Reset mid-ownership: all outputs clear asynchronously. After resetn rises, arbitration restarts from IDLE with A favored on a tie.
- Requests are level-sensitive. A pulse of 1 cycle sampled at an edge earns one owned cycle.

## Test plan
- Reset: drive resetn=0 mid-OWN_B -> grant_b, sel, data_valid and data_out clear immediately. Release resetn with both req high -> grant_a=1 after the first edge.
- Single requester: req_a=1 for 10 cycles with data_a=8'hA5 -> grant_a high from edge 1 to edge 10, sel=0, data_out=8'hA5 and data_valid=1 from edge 2. grant_a falls 1 clock after req_a drops.
- Preemption (SLICE=4): req_a and req_b held high -> grant alternates A,A,A,A,B,B,B,B,A…, sel toggles every 4 cycles, and data_out follows data_a=8'h0F / data_b=8'hF0 with 1-cycle lag.
- Early release: A owns; req_a drops on its 2nd owned cycle while req_b=1 -> grant_b rises at the next edge, with no IDLE cycle and no overlap.
- Coincident release and expiry: req_a drops exactly when the counter reaches 4 and req_b=0 -> IDLE, grant_a=0, and sel stays 0.
- Tie after idle: B owned last; both requests rise together -> A is granted first; the next tie from IDLE grants B.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin time-sliced arbiter sharing one registered WIDTH-bit output between requesters A and B
module mux_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             grant_a,
   output logic             grant_b,
   output logic             sel,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid
);
   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
   localparam logic [7:0] SLICE_C = 8'(SLICE);
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic last_b_q, last_b_d, sel_q, sel_d, valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic owner_b, mine, other, own, go_b, entry;
   always_comb begin
      own = state_q != IDLE;
      owner_b = state_q == OWN_B;
      mine = owner_b ? req_b : req_a;
      other = owner_b ? req_a : req_b;
      go_b = req_b & (~req_a | ~last_b_q);
      state_d = !own ? ((req_a | req_b) ? (go_b ? OWN_B : OWN_A) : IDLE)
              : (other && (!mine || cnt_q == SLICE_C)) ? (owner_b ? OWN_A : OWN_B)
              : !mine ? IDLE : state_q;
      entry = state_d != state_q && state_d != IDLE;
      cnt_d = entry ? 8'd1 : state_d == IDLE ? 8'd0 : (cnt_q < SLICE_C ? cnt_q + 8'd1 : cnt_q);
      last_b_d = entry ? state_d == OWN_B : last_b_q;
      sel_d = state_d == OWN_A ? 1'b0 : state_d == OWN_B ? 1'b1 : sel_q;
      valid_d = own;
      data_d = own ? (owner_b ? data_b : data_a) : data_q;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q <= 8'd0;
         last_b_q <= 1'b1;
         sel_q <= 1'b0;
         valid_q <= 1'b0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         last_b_q <= last_b_d;
         sel_q <= sel_d;
         valid_q <= valid_d;
         data_q <= data_d;
      end
   end
   assign grant_a = state_q == OWN_A;
   assign grant_b = state_q == OWN_B;
   assign sel = sel_q;
   assign data_valid = valid_q;
   assign data_out = data_q;
endmodule
